adc_serial_capture_mc: RTL and testbench

- Parametrised multi-channel successor to the single-ADC AD7476 serializer.
- Drives one shared CSn/SCLK pair to NUM_CH AD7476-class ADCs, each with its own SDATA line, and captures every channel in parallel.
- Adds a programmable sample-period timer, single-shot mode and tagged 32-bit output words with valid/ready handshake.
- Adds overrun detection with a drop counter. Feeds the sensor FIFO/DMA path in the FPGA IP.

---
 rtl/adc_serial_capture_mc.sv | 251 +++++++++++++++++++++++++
 tb/tb_adc_serial_capture_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture_mc.sv
// ============================================================================
// adc_serial_capture_mc: shared CSn/SCLK capture of NUM_CH AD7476-class ADCs
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_serial_capture_mc #(
    parameter int NUM_CH       = 2,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic [15:0]       sample_period_i,
    output logic              csn_o,
    output logic              sclk_o,
    input  logic [NUM_CH-1:0] sdata_i,
    output logic              smp_valid_o,
    input  logic              smp_ready_i,
    output logic [31:0]       smp_data_o,
    output logic              overrun_o,
    input  logic              clr_overrun_i,
    output logic [7:0]        drop_cnt_o,
    output logic              busy_o,
    output logic [2:0]        fsm_st_o
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_setup = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_quiet = 3'd3;
    localparam logic [2:0] c_st_wait  = 3'd4;

    localparam int c_cnt_max = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_bit_w   = $clog2(FRAME_BITS + 1);
    localparam int c_idx_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [c_cnt_w-1:0] c_div_last   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_quiet_last = c_cnt_w'(QUIET_CYCLES - 1);
    localparam logic [c_bit_w-1:0] c_bits_all   = c_bit_w'(FRAME_BITS);
    localparam logic [c_idx_w-1:0] c_last_ch    = c_idx_w'(NUM_CH - 1);

    logic [2:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [c_bit_w-1:0] bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic               csn_q, csn_d;
    logic [15:0]        per_q, per_d;
    logic [15:0]        timer_q, timer_d;
    logic               w_shift_en;
    logic               w_frame_done;

    logic [15:0]        w_sample [NUM_CH];
    logic [15:0]        buf_q [NUM_CH];
    logic [11:0]        bseq_q;
    logic [11:0]        seq_q;
    logic               full_q;
    logic [c_idx_w-1:0] rd_q;
    logic               ovr_q, ovr_d;
    logic [7:0]         drop_q, drop_d;
    logic               w_accept;
    logic               w_last_acc;
    logic               w_load;
    logic               w_drop;

    // The timer reads 1 in the first CSn-low cycle, so WAIT releases exactly
    // one latched period after the previous CSn falling edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sclk_d       = 1'b1;
        per_d        = per_q;
        timer_d      = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        w_shift_en   = 1'b0;
        w_frame_done = 1'b0;
        case (state_q)
            c_st_idle: begin
                cnt_d = '0;
                bit_d = '0;
                if (enable_i || start_i) begin
                    state_d = c_st_setup;
                    per_d   = sample_period_i;
                    timer_d = 16'd1;
                end
            end
            c_st_setup: begin
                bit_d = '0;
                if (cnt_q == c_div_last) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = c_st_shift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_shift: begin
                sclk_d = sclk_q;
                if (cnt_q == c_div_last) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d     = 1'b1;
                        w_shift_en = 1'b1;
                        bit_d      = bit_q + 1'b1;
                    end else if (bit_q == c_bits_all) begin
                        w_frame_done = 1'b1;
                        state_d      = c_st_quiet;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_quiet: begin
                if (cnt_q == c_quiet_last) begin
                    cnt_d   = '0;
                    state_d = enable_i ? c_st_wait : c_st_idle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_wait: begin
                if (!enable_i) begin
                    state_d = c_st_idle;
                end else if (timer_q >= per_q) begin
                    state_d = c_st_setup;
                    timer_d = 16'd1;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
        csn_d = !((state_d == c_st_setup) || (state_d == c_st_shift));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b1;
            csn_q   <= 1'b1;
            per_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            per_q   <= per_d;
            timer_q <= timer_d;
        end
    end

    // Only the last DATA_BITS bits shifted in survive, so the register is that wide.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [DATA_BITS-1:0] shreg_q;
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    shreg_q <= '0;
                end else if (w_shift_en) begin
                    shreg_q <= (shreg_q << 1) | DATA_BITS'(sdata_i[k]);
                end
            end
            assign w_sample[k] = 16'(shreg_q);
        end
    endgenerate

    assign w_accept   = full_q && smp_ready_i;
    assign w_last_acc = w_accept && (rd_q == c_last_ch);
    assign w_load     = !full_q || w_last_acc;
    assign w_drop     = w_frame_done && !w_load;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            full_q <= 1'b0;
            rd_q   <= '0;
            bseq_q <= '0;
            seq_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            if (w_frame_done) begin
                seq_q <= seq_q + 12'd1;
            end
            if (w_frame_done && w_load) begin
                full_q <= 1'b1;
                rd_q   <= '0;
                bseq_q <= seq_q;
                for (int k = 0; k < NUM_CH; k++) begin
                    buf_q[k] <= w_sample[k];
                end
            end else if (w_accept) begin
                if (rd_q == c_last_ch) begin
                    full_q <= 1'b0;
                    rd_q   <= '0;
                end else begin
                    rd_q <= rd_q + 1'b1;
                end
            end
        end
    end

    // A clear landing with a drop is applied first, so that drop counts as 1.
    always_comb begin
        ovr_d  = ovr_q;
        drop_d = drop_q;
        if (clr_overrun_i) begin
            ovr_d  = 1'b0;
            drop_d = 8'd0;
        end
        if (w_drop) begin
            ovr_d = 1'b1;
            if (drop_d != 8'hFF) begin
                drop_d = drop_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ovr_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            ovr_q  <= ovr_d;
            drop_q <= drop_d;
        end
    end

    assign csn_o       = csn_q;
    assign sclk_o      = sclk_q;
    assign smp_valid_o = full_q;
    assign smp_data_o  = {4'(rd_q), bseq_q, buf_q[rd_q]};
    assign overrun_o   = ovr_q;
    assign drop_cnt_o  = drop_q;
    assign busy_o      = (state_q != c_st_idle);
    assign fsm_st_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_capture_mc.sv
// ============================================================================
// tb_adc_serial_capture_mc: directed bench with ADC models for the capture core
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_serial_capture_mc;

    localparam int NUM_CH = 2;
    localparam int FB     = 16;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              start;
    logic [15:0]       period;
    logic              ready;
    logic              clr;
    logic [NUM_CH-1:0] sdata = '0;
    logic              csn_o;
    logic              sclk_o;
    logic              smp_valid_o;
    logic [31:0]       smp_data_o;
    logic              overrun_o;
    logic [7:0]        drop_cnt_o;
    logic              busy_o;
    logic [2:0]        fsm_st_o;

    always #5 clk = ~clk;

    adc_serial_capture_mc #(
        .NUM_CH(NUM_CH), .FRAME_BITS(FB), .DATA_BITS(12), .CLK_DIV(2), .QUIET_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .start_i(start),
        .sample_period_i(period), .csn_o(csn_o), .sclk_o(sclk_o), .sdata_i(sdata),
        .smp_valid_o(smp_valid_o), .smp_ready_i(ready), .smp_data_o(smp_data_o),
        .overrun_o(overrun_o), .clr_overrun_i(clr), .drop_cnt_o(drop_cnt_o),
        .busy_o(busy_o), .fsm_st_o(fsm_st_o)
    );

    // ADC model: next bit, MSB first, presented on every SCLK falling edge.
    logic [15:0] adc_word [NUM_CH];
    int          adc_idx = 0;
    always @(negedge csn_o or negedge sclk_o) begin
        if (sclk_o) begin
            adc_idx = FB;
        end else if (!csn_o && adc_idx > 0) begin
            adc_idx = adc_idx - 1;
            for (int k = 0; k < NUM_CH; k++) sdata[k] = adc_word[k][adc_idx];
        end
    end

    int          cyc = 0;
    logic [31:0] got_q[$];
    int          fall_q[$];
    int          rise_cnt = 0;
    int          rise_in_frame = 0;
    int          low_len = 0;
    int          last_rises = 0;
    int          last_low = 0;
    int          stab_err = 0;
    logic        prev_csn = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (smp_valid_o && ready) got_q.push_back(smp_data_o);
        if (prev_hold && smp_valid_o && smp_data_o !== prev_data) stab_err++;
        prev_hold = smp_valid_o && !ready;
        prev_data = smp_data_o;
        if (prev_csn && !csn_o) begin
            fall_q.push_back(cyc);
            rise_in_frame = 0;
            low_len = 0;
        end
        if (!csn_o) begin
            low_len++;
            if (!prev_sclk && sclk_o) rise_in_frame++;
        end
        if (!prev_csn && csn_o) begin
            rise_cnt++;
            last_rises = rise_in_frame;
            last_low = low_len;
        end
        prev_csn = csn_o;
        prev_sclk = sclk_o;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic int cur(input int which);
        if (which == 0) return fall_q.size();
        if (which == 1) return rise_cnt;
        return csn_o ? 0 : rise_in_frame;
    endfunction

    task automatic wait_ge(input int which, input int target, input string name);
        int k = 0;
        int v;
        v = cur(which);
        while (v < target && k < 5000) begin
            @(negedge clk);
            k++;
            v = cur(which);
        end
        n_tests++;
        if (v < target) begin
            n_fail++;
            $display("FAIL %s: timed out at %0d, required %0d", name, v, target);
        end
        tick(1);
    endtask

    task automatic wait_done(input int nwords, input string name);
        int k = 0;
        while (!(got_q.size() >= nwords && !busy_o && !smp_valid_o) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k >= 5000) begin
            n_fail++;
            $display("FAIL %s: timed out with %0d words, required %0d", name, got_q.size(), nwords);
        end
        tick(1);
    endtask

    vec_t vecs[4];

    initial begin
        int b;
        int fb;
        int rb;

        vecs[0] = '{w0: 16'h0ABC, w1: 16'h0123, e0: 32'h00000ABC, e1: 32'h10000123};
        vecs[1] = '{w0: 16'hFFFF, w1: 16'h8001, e0: 32'h00010FFF, e1: 32'h10010001};
        vecs[2] = '{w0: 16'h5A5A, w1: 16'hA5A5, e0: 32'h00020A5A, e1: 32'h100205A5};
        vecs[3] = '{w0: 16'h0000, w1: 16'hF000, e0: 32'h00030000, e1: 32'h10030000};

        rst_n = 1'b0; enable = 1'b0; start = 1'b0; ready = 1'b1; clr = 1'b0;
        period = 16'd200;
        adc_word[0] = 16'h0ABC; adc_word[1] = 16'h0123;

        do_reset();
        tick(5);
        check("rst_csn", 32'(csn_o), 32'd1);
        check("rst_sclk", 32'(sclk_o), 32'd1);
        check("rst_valid", 32'(smp_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_fsm", 32'(fsm_st_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        check("rst_data", smp_data_o, 32'h0);
        tick(40);
        check("idle_csn", 32'(csn_o), 32'd1);
        check("idle_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 4; i++) begin
            adc_word[0] = vecs[i].w0;
            adc_word[1] = vecs[i].w1;
            b  = got_q.size();
            fb = fall_q.size();
            pulse_start();
            if (i == 1) begin
                tick(10);
                pulse_start();
            end
            wait_done(b + 2, "vec_done");
            check($sformatf("vec%0d_ch0", i), got_q[b], vecs[i].e0);
            check($sformatf("vec%0d_ch1", i), got_q[b + 1], vecs[i].e1);
            check($sformatf("vec%0d_frames", i), 32'(fall_q.size() - fb), 32'd1);
            check($sformatf("vec%0d_sclk_rises", i), 32'(last_rises), 32'd16);
            check($sformatf("vec%0d_csn_low", i), 32'(last_low), 32'd66);
            check($sformatf("vec%0d_fsm", i), 32'(fsm_st_o), 32'd0);
        end

        // Continuous conversions at a fixed period.
        do_reset();
        adc_word[0] = 16'h0ABC; adc_word[1] = 16'h0123;
        period = 16'd200;
        b  = got_q.size();
        fb = fall_q.size();
        enable = 1'b1;
        wait_ge(0, fb + 5, "cont_falls");
        enable = 1'b0;
        wait_done(b + 10, "cont_done");
        check("cont_nframes", 32'(fall_q.size() - fb), 32'd5);
        for (int i = 0; i < 4; i++)
            check($sformatf("cont_period%0d", i), 32'(fall_q[fb + i + 1] - fall_q[fb + i]), 32'd200);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("cont_ch0_f%0d", i), got_q[b + 2 * i], {4'h0, 12'(i), 16'h0ABC});
            check($sformatf("cont_ch1_f%0d", i), got_q[b + 2 * i + 1], {4'h1, 12'(i), 16'h0123});
        end
        check("cont_overrun", 32'(overrun_o), 32'd0);

        // Back-pressure: hold ready low across three frames.
        do_reset();
        ready = 1'b0;
        period = 16'd100;
        rb = rise_cnt;
        b  = got_q.size();
        enable = 1'b1;
        wait_ge(1, rb + 3, "bp_frames");
        enable = 1'b0;
        check("bp_overrun", 32'(overrun_o), 32'd1);
        check("bp_drop_cnt", 32'(drop_cnt_o), 32'd2);
        check("bp_valid", 32'(smp_valid_o), 32'd1);
        check("bp_held_data", smp_data_o, 32'h00000ABC);
        check("bp_stable", 32'(stab_err), 32'd0);
        tick(10);
        check("bp_idle", 32'(busy_o), 32'd0);
        ready = 1'b1;
        wait_done(b + 2, "bp_drain");
        check("bp_word0", got_q[b], 32'h00000ABC);
        check("bp_word1", got_q[b + 1], 32'h10000123);
        pulse_start();
        wait_done(b + 4, "bp_next");
        check("bp_seq_jump", got_q[b + 2], 32'h00030ABC);
        check("bp_overrun_sticky", 32'(overrun_o), 32'd1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_overrun", 32'(overrun_o), 32'd0);
        check("clr_drop", 32'(drop_cnt_o), 32'd0);

        // Enable dropped after the seventh SCLK rise.
        do_reset();
        period = 16'd200;
        b  = got_q.size();
        fb = fall_q.size();
        enable = 1'b1;
        wait_ge(2, 7, "b7_bit");
        enable = 1'b0;
        wait_done(b + 2, "b7_done");
        tick(250);
        check("b7_rises", 32'(last_rises), 32'd16);
        check("b7_csn_low", 32'(last_low), 32'd66);
        check("b7_nframes", 32'(fall_q.size() - fb), 32'd1);
        check("b7_fsm", 32'(fsm_st_o), 32'd0);
        check("b7_word0", got_q[b], 32'h00000ABC);
        check("b7_word1", got_q[b + 1], 32'h10000123);

        // Reset in the middle of SHIFT.
        b = got_q.size();
        pulse_start();
        wait_ge(2, 5, "rm_bit");
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rm_csn", 32'(csn_o), 32'd1);
        check("rm_valid", 32'(smp_valid_o), 32'd0);
        check("rm_fsm", 32'(fsm_st_o), 32'd0);
        tick(5);
        check("rm_no_word", 32'(got_q.size() - b), 32'd0);
        pulse_start();
        wait_done(b + 2, "rm_next");
        check("rm_seq0_ch0", got_q[b], 32'h00000ABC);
        check("rm_seq0_ch1", got_q[b + 1], 32'h10000123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
